// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_pkg;

  // Widest register address the shadow entries can hold; narrower
  // addresses are zero-extended into this field.
  localparam int MAX_REG_AW = 8;

  // Downstream stage indices for the classic 5-stage pipeline.
  localparam int STG_EX  = 1;
  localparam int STG_MEM = 2;
  localparam int STG_WB  = 3;

  // Forward-select encoding: 0 means register file, k means stage k.
  localparam int FWD_RF  = 0;
  localparam int FWD_EX  = STG_EX;
  localparam int FWD_MEM = STG_MEM;
  localparam int FWD_WB  = STG_WB;

  // Per-stage record of what the instruction in that stage will write.
  typedef struct packed {
    logic                  valid;
    logic [MAX_REG_AW-1:0] rd;
    logic                  wen;
    logic                  is_load;
  } shadow_entry_t;

  // Build a shadow entry from decode fields.
  function automatic shadow_entry_t make_entry(
    input logic                  valid,
    input logic [MAX_REG_AW-1:0] rd,
    input logic                  wen,
    input logic                  is_load
  );
    shadow_entry_t e;
    e.valid   = valid;
    e.rd      = rd;
    e.wen     = wen;
    e.is_load = is_load;
    return e;
  endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter with synchronous reset and count enable.
module pipe_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  // Count enabled events, holding at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (en && !(&count)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller: tracks in-flight destinations per stage, detects
// load-use stalls, selects forwarding sources and counts stall/flush events.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int NUM_STAGES = 5,
  parameter int REG_AW     = 5,
  parameter int LOAD_READY = 2,
  parameter int CNT_W      = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                id_valid,
  input  logic [REG_AW-1:0]                   id_rs1,
  input  logic [REG_AW-1:0]                   id_rs2,
  input  logic                                id_use_rs1,
  input  logic                                id_use_rs2,
  input  logic [REG_AW-1:0]                   id_rd,
  input  logic                                id_wen,
  input  logic                                id_is_load,
  input  logic                                ex_branch_taken,
  output logic                                stall,
  output logic                                flush,
  output logic [$clog2(NUM_STAGES-1)-1:0]     fwd_sel_rs1,
  output logic [$clog2(NUM_STAGES-1)-1:0]     fwd_sel_rs2,
  output logic [NUM_STAGES-3:0]               stage_valid,
  output logic [CNT_W-1:0]                    stall_cnt,
  output logic [CNT_W-1:0]                    flush_cnt
);

  localparam int D  = NUM_STAGES - 2;
  localparam int FW = $clog2(D + 1);

  shadow_entry_t         entry_reg [1:D];
  shadow_entry_t         entry_next;
  logic [MAX_REG_AW-1:0] rs1_ext;
  logic [MAX_REG_AW-1:0] rs2_ext;
  logic [MAX_REG_AW-1:0] rd_ext;
  logic [D-1:0]          hit_rs1;
  logic [D-1:0]          hit_rs2;
  logic [D-1:0]          load_hit;
  logic [FW-1:0]         fwd_rs1_next;
  logic [FW-1:0]         fwd_rs2_next;

  assign rs1_ext = MAX_REG_AW'(id_rs1);
  assign rs2_ext = MAX_REG_AW'(id_rs2);
  assign rd_ext  = MAX_REG_AW'(id_rd);

  // A branch in EX kills IF/ID, and that overrides any load-use stall.
  assign flush = ex_branch_taken;
  assign stall = id_valid && !flush && (|load_hit);

  // Per-stage hazard match; only stages whose load data is not yet
  // forwardable can raise a load-use stall.
  generate
    for (genvar gi = 1; gi <= D; gi++) begin : g_hazard
      assign hit_rs1[gi-1] = entry_reg[gi].valid && entry_reg[gi].wen &&
                             (entry_reg[gi].rd == rs1_ext) &&
                             (id_rs1 != '0) && id_use_rs1;
      assign hit_rs2[gi-1] = entry_reg[gi].valid && entry_reg[gi].wen &&
                             (entry_reg[gi].rd == rs2_ext) &&
                             (id_rs2 != '0) && id_use_rs2;
      if (gi <= LOAD_READY - 1) begin : g_load_window
        assign load_hit[gi-1] = entry_reg[gi].is_load &&
                                (hit_rs1[gi-1] || hit_rs2[gi-1]);
      end else begin : g_no_load_window
        assign load_hit[gi-1] = 1'b0;
      end
      assign stage_valid[gi-1] = entry_reg[gi].valid;
    end
  endgenerate

  // Pick the youngest matching stage: scan oldest to youngest so the
  // smallest index is written last.
  always_comb begin
    fwd_rs1_next = FW'(FWD_RF);
    fwd_rs2_next = FW'(FWD_RF);
    for (int k = D; k >= 1; k--) begin
      if (hit_rs1[k-1]) fwd_rs1_next = FW'(k);
      if (hit_rs2[k-1]) fwd_rs2_next = FW'(k);
    end
  end

  assign fwd_sel_rs1 = fwd_rs1_next;
  assign fwd_sel_rs2 = fwd_rs2_next;

  // New entry for EX: the decode instruction if it advances, else a bubble.
  always_comb begin
    entry_next = make_entry(1'b0, '0, 1'b0, 1'b0);
    if (id_valid && !stall && !flush) begin
      entry_next = make_entry(1'b1, rd_ext, id_wen, id_is_load);
    end
  end

  // Stage 1 register: capture decode or insert a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      entry_reg[1] <= make_entry(1'b0, '0, 1'b0, 1'b0);
    end else begin
      entry_reg[1] <= entry_next;
    end
  end

  // Stages 2..D: unconditional shift; the oldest entry falls off the end.
  generate
    for (genvar gi = 2; gi <= D; gi++) begin : g_shift
      always_ff @(posedge clk) begin
        if (rst) begin
          entry_reg[gi] <= make_entry(1'b0, '0, 1'b0, 1'b0);
        end else begin
          entry_reg[gi] <= entry_reg[gi-1];
        end
      end
    end
  endgenerate

  pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (stall),
    .count (stall_cnt)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (flush),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl (default depth, plus a 4-bit counter copy).
module tb_pipe_hazard_ctrl;

  localparam int NS = 5;
  localparam int AW = 5;
  localparam int LR = 2;
  localparam int D  = NS - 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          id_valid;
  logic [AW-1:0] id_rs1, id_rs2, id_rd;
  logic          id_use_rs1, id_use_rs2, id_wen, id_is_load;
  logic          ex_branch_taken;

  logic          stall, flush;
  logic [1:0]    fwd_sel_rs1, fwd_sel_rs2;
  logic [D-1:0]  stage_valid;
  logic [31:0]   stall_cnt, flush_cnt;

  logic          s_stall, s_flush;
  logic [1:0]    s_fwd1, s_fwd2;
  logic [D-1:0]  s_sv;
  logic [3:0]    s_stall_cnt, s_flush_cnt;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_wen(id_wen),
    .id_is_load(id_is_load), .ex_branch_taken(ex_branch_taken),
    .stall(stall), .flush(flush), .fwd_sel_rs1(fwd_sel_rs1), .fwd_sel_rs2(fwd_sel_rs2),
    .stage_valid(stage_valid), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_hazard_ctrl #(.CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_wen(id_wen),
    .id_is_load(id_is_load), .ex_branch_taken(ex_branch_taken),
    .stall(s_stall), .flush(s_flush), .fwd_sel_rs1(s_fwd1), .fwd_sel_rs2(s_fwd2),
    .stage_valid(s_sv), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  typedef struct {
    logic        stall;
    logic        flush;
    logic [1:0]  fwd1;
    logic [1:0]  fwd2;
    logic [2:0]  sv;
    logic [31:0] scnt;
    logic [31:0] fcnt;
    logic [3:0]  scnt_small;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   n_checks = 0;
  int   n_errs   = 0;

  // Reference state: what each downstream stage holds, by age.
  bit          m_v  [1:D];
  logic [4:0]  m_rd [1:D];
  bit          m_w  [1:D];
  bit          m_ld [1:D];
  logic [31:0] m_sc, m_fc;
  int          m_small;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Monitor: compare DUT outputs mid-cycle against the scoreboard.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      chk("stall",      32'(stall),       32'(cur.stall));
      chk("flush",      32'(flush),       32'(cur.flush));
      chk("fwd_rs1",    32'(fwd_sel_rs1), 32'(cur.fwd1));
      chk("fwd_rs2",    32'(fwd_sel_rs2), 32'(cur.fwd2));
      chk("stage_valid",32'(stage_valid), 32'(cur.sv));
      chk("stall_cnt",  stall_cnt,        cur.scnt);
      chk("flush_cnt",  flush_cnt,        cur.fcnt);
      chk("stall_cnt4", 32'(s_stall_cnt), 32'(cur.scnt_small));
    end
  end

  // Drive one decode cycle, push its expected outputs, advance the reference.
  task automatic cycle(input bit r, input bit v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input bit u1, input bit u2, input logic [4:0] rd,
                       input bit w, input bit ld, input bit br);
    exp_t e;
    bit   h1, h2, haz_ld;
    @(posedge clk); #1;
    rst = r; id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    id_rd = rd; id_wen = w; id_is_load = ld; ex_branch_taken = br;
    e.fwd1 = 2'd0; e.fwd2 = 2'd0; haz_ld = 1'b0;
    for (int k = 1; k <= D; k++) begin
      h1 = m_v[k] && m_w[k] && (m_rd[k] == rs1) && (rs1 != 5'd0) && u1;
      h2 = m_v[k] && m_w[k] && (m_rd[k] == rs2) && (rs2 != 5'd0) && u2;
      if (h1 && e.fwd1 == 2'd0) e.fwd1 = 2'(k);
      if (h2 && e.fwd2 == 2'd0) e.fwd2 = 2'(k);
      if ((h1 || h2) && m_ld[k] && k < LR) haz_ld = 1'b1;
    end
    e.flush = br;
    e.stall = v && !br && haz_ld;
    e.sv = {m_v[3], m_v[2], m_v[1]};
    e.scnt = m_sc;
    e.fcnt = m_fc;
    e.scnt_small = 4'(m_small);
    sb.push_back(e);
    if (r) begin
      for (int k = 1; k <= D; k++) begin
        m_v[k] = 0; m_rd[k] = 5'd0; m_w[k] = 0; m_ld[k] = 0;
      end
      m_sc = 32'd0; m_fc = 32'd0; m_small = 0;
    end else begin
      for (int k = D; k >= 2; k--) begin
        m_v[k] = m_v[k-1]; m_rd[k] = m_rd[k-1]; m_w[k] = m_w[k-1]; m_ld[k] = m_ld[k-1];
      end
      if (v && !e.stall && !br) begin
        m_v[1] = 1; m_rd[1] = rd; m_w[1] = w; m_ld[1] = ld;
      end else begin
        m_v[1] = 0; m_rd[1] = 5'd0; m_w[1] = 0; m_ld[1] = 0;
      end
      if (e.stall) begin
        if (m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 32'd1;
        if (m_small < 15) m_small++;
      end
      if (br && m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 32'd1;
    end
  endtask

  task automatic idle();
    cycle(0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; id_valid = 0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_rd = '0; id_wen = 0; id_is_load = 0; ex_branch_taken = 0;
    for (int k = 1; k <= D; k++) begin
      m_v[k] = 0; m_rd[k] = 5'd0; m_w[k] = 0; m_ld[k] = 0;
    end
    m_sc = 32'd0; m_fc = 32'd0; m_small = 0;
    repeat (2) @(posedge clk);

    // Reset state
    idle();
    idle();

    // Load x5 then a consumer of x5: one stall, then forward from stage 2
    cycle(0, 1, 5'd0, 5'd0, 0, 0, 5'd5, 1, 1, 0);
    cycle(0, 1, 5'd5, 5'd0, 1, 0, 5'd6, 1, 0, 0);
    cycle(0, 1, 5'd5, 5'd0, 1, 0, 5'd6, 1, 0, 0);
    idle();
    @(negedge clk);
    chk("stall_cnt_once", stall_cnt, 32'd1);
    idle(); idle();

    // ALU writes x7; rs2 consumers forward from stage 1 then stage 2
    cycle(0, 1, 5'd0, 5'd0, 0, 0, 5'd7, 1, 0, 0);
    cycle(0, 1, 5'd0, 5'd7, 0, 1, 5'd9, 1, 0, 0);
    cycle(0, 1, 5'd0, 5'd7, 0, 1, 5'd10, 1, 0, 0);
    idle(); idle(); idle();

    // Two writers of x3: youngest wins; x0 writer never forwards
    cycle(0, 1, 5'd0, 5'd0, 0, 0, 5'd3, 1, 0, 0);
    cycle(0, 1, 5'd0, 5'd0, 0, 0, 5'd3, 1, 0, 0);
    cycle(0, 1, 5'd3, 5'd3, 1, 1, 5'd0, 1, 0, 0);
    cycle(0, 1, 5'd0, 5'd0, 1, 1, 5'd4, 1, 0, 0);
    idle(); idle(); idle();

    // Unused source does not stall on a load
    cycle(0, 1, 5'd0, 5'd0, 0, 0, 5'd5, 1, 1, 0);
    cycle(0, 1, 5'd5, 5'd5, 0, 0, 5'd8, 1, 0, 0);
    idle(); idle(); idle();

    // Branch taken with a load-use hazard: flush wins, bubble enters
    cycle(0, 1, 5'd0, 5'd0, 0, 0, 5'd5, 1, 1, 0);
    cycle(0, 1, 5'd5, 5'd0, 1, 0, 5'd6, 1, 0, 1);
    idle(); idle(); idle();

    // Reset with three valid stages
    cycle(0, 1, 5'd0, 5'd0, 0, 0, 5'd11, 1, 0, 0);
    cycle(0, 1, 5'd0, 5'd0, 0, 0, 5'd12, 1, 0, 0);
    cycle(0, 1, 5'd0, 5'd0, 0, 0, 5'd13, 1, 0, 0);
    cycle(1, 1, 5'd13, 5'd0, 1, 0, 5'd1, 1, 0, 0);
    idle();
    @(negedge clk);
    chk("sv_after_rst", 32'(stage_valid), 32'd0);
    chk("cnt_after_rst", stall_cnt, 32'd0);

    // Random traffic over a small register window to provoke hazards
    for (int i = 0; i < 80; i++) begin
      cycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
            5'($urandom_range(0, 6)), 5'($urandom_range(0, 6)),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1),
            5'($urandom_range(0, 6)), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0));
    end

    // Clear, then 20 load-use stalls to saturate the 4-bit counter
    cycle(1, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      cycle(0, 1, 5'd0, 5'd0, 0, 0, 5'd5, 1, 1, 0);
      cycle(0, 1, 5'd5, 5'd0, 1, 0, 5'd6, 1, 0, 0);
    end
    idle();
    @(negedge clk);
    chk("sat_small", 32'(s_stall_cnt), 32'd15);
    chk("sat_full", stall_cnt, 32'd20);

    @(posedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
      n_checks++;
      n_errs++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
